// File: rtl/snake_step_ctrl_if.sv
// Bus between the snake movement sequencer and the body store
// (head-at-index-0 shift FIFO with push/pop, length and a registered read port).
interface snake_step_ctrl_if #(
   parameter int XW = 6,
   parameter int YW = 5
);
   logic [7:0]       body_len;
   logic [7:0]       rd_idx;
   logic [XW+YW-1:0] rd_data;
   logic             push;
   logic             pop;
   logic [XW+YW-1:0] push_data;

   modport master (
      input  body_len,
      input  rd_data,
      output rd_idx,
      output push,
      output pop,
      output push_data
   );

   modport slave (
      output body_len,
      output rd_data,
      input  rd_idx,
      input  push,
      input  pop,
      input  push_data
   );
endinterface

// File: rtl/snake_step_ctrl.sv
// Per-tick snake movement sequencer: drains/seeds the body store, computes the
// next head, scans the body for self collision and commits a push or push+pop.
module snake_step_ctrl #(
   parameter int XW       = 6,
   parameter int YW       = 5,
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int MAX_LEN  = 8,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 20,
   parameter int START_Y  = 15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  tick,
   input  logic [1:0]            dir_in,
   input  logic [XW-1:0]         food_x,
   input  logic [YW-1:0]         food_y,
   snake_step_ctrl_if.master     bus,
   output logic [XW-1:0]         head_x,
   output logic [YW-1:0]         head_y,
   output logic [1:0]            dir_out,
   output logic                  ate,
   output logic                  game_over,
   output logic                  busy
);
   localparam logic [XW-1:0] X_LAST   = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(GRID_H - 1);
   localparam logic [XW-1:0] START_HX = XW'(START_X);
   localparam logic [YW-1:0] START_HY = YW'(START_Y);
   localparam logic [XW-1:0] SEED_X0  = XW'(START_X - INIT_LEN + 1);
   localparam logic [7:0]    SEED_END = 8'(INIT_LEN - 1);
   localparam logic [7:0]    LEN_CAP  = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE, ST_DRAIN, ST_SEED, ST_RUN, ST_CALC, ST_SCAN, ST_COMMIT, ST_OVER
   } state_t;

   state_t            state_reg, state_next;
   logic [XW-1:0]     head_x_reg, head_x_next, nh_x_reg, nh_x_next;
   logic [YW-1:0]     head_y_reg, head_y_next, nh_y_reg, nh_y_next;
   logic [1:0]        dir_reg, dir_next;
   logic              game_over_reg, game_over_next;
   logic              pending_reg, pending_next;
   logic              drain_wait_reg, drain_wait_next;
   logic              grow_reg, grow_next, eat_reg, eat_next;
   logic [7:0]        cnt_reg, cnt_next, scan_n_reg, scan_n_next;
   logic [7:0]        rd_idx_reg, rd_idx_next;
   logic              push_reg, push_next, pop_reg, pop_next, ate_reg, ate_next;
   logic [XW+YW-1:0]  push_data_reg, push_data_next;

   logic              wall;
   logic [XW-1:0]     step_x;
   logic [YW-1:0]     step_y;
   logic              calc_eat, calc_grow;
   logic [7:0]        calc_n;

   // Candidate head for the current direction; no wrap, the wall flag covers the edges.
   always_comb begin
      step_x = head_x_reg;
      step_y = head_y_reg;
      wall   = 1'b0;
      case (dir_reg)
         2'd0: begin wall = (head_y_reg == '0);    step_y = head_y_reg - YW'(1); end
         2'd1: begin wall = (head_x_reg == X_LAST); step_x = head_x_reg + XW'(1); end
         2'd2: begin wall = (head_y_reg == Y_LAST); step_y = head_y_reg + YW'(1); end
         default: begin wall = (head_x_reg == '0); step_x = head_x_reg - XW'(1); end
      endcase
      calc_eat  = (step_x == food_x) && (step_y == food_y);
      calc_grow = calc_eat && (bus.body_len < LEN_CAP);
      // When moving, the tail vacates this tick, so it is not a collision target.
      calc_n    = calc_grow ? bus.body_len : bus.body_len - 8'd1;
   end

   always_comb begin
      state_next      = state_reg;
      head_x_next     = head_x_reg;
      head_y_next     = head_y_reg;
      nh_x_next       = nh_x_reg;
      nh_y_next       = nh_y_reg;
      dir_next        = dir_reg;
      game_over_next  = game_over_reg;
      pending_next    = pending_reg;
      drain_wait_next = drain_wait_reg;
      grow_next       = grow_reg;
      eat_next        = eat_reg;
      cnt_next        = cnt_reg;
      scan_n_next     = scan_n_reg;
      rd_idx_next     = rd_idx_reg;
      push_data_next  = push_data_reg;
      push_next       = 1'b0;
      pop_next        = 1'b0;
      ate_next        = 1'b0;

      if (tick && (state_reg == ST_CALC || state_reg == ST_SCAN || state_reg == ST_COMMIT))
         pending_next = 1'b1;

      case (state_reg)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_next      = ST_DRAIN;
               game_over_next  = 1'b0;
               dir_next        = 2'd1;
               pending_next    = 1'b0;
               drain_wait_next = 1'b0;
            end
         end
         ST_DRAIN: begin
            // Pop, then idle a cycle so body_len reflects the pop before the next decision.
            if (drain_wait_reg) begin
               drain_wait_next = 1'b0;
            end else if (bus.body_len != 8'd0) begin
               pop_next        = 1'b1;
               drain_wait_next = 1'b1;
            end else begin
               state_next = ST_SEED;
               cnt_next   = 8'd0;
            end
         end
         ST_SEED: begin
            push_next      = 1'b1;
            push_data_next = {SEED_X0 + XW'(cnt_reg), START_HY};
            cnt_next       = cnt_reg + 8'd1;
            if (cnt_reg == SEED_END) begin
               head_x_next = START_HX;
               head_y_next = START_HY;
               state_next  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (tick || pending_reg) begin
               pending_next = 1'b0;
               if (dir_in != (dir_reg ^ 2'd2))
                  dir_next = dir_in;
               state_next = ST_CALC;
            end
         end
         ST_CALC: begin
            if (wall) begin
               game_over_next = 1'b1;
               state_next     = ST_OVER;
            end else begin
               nh_x_next   = step_x;
               nh_y_next   = step_y;
               grow_next   = calc_grow;
               eat_next    = calc_eat;
               scan_n_next = calc_n;
               cnt_next    = 8'd0;
               rd_idx_next = 8'd0;
               state_next  = (calc_n == 8'd0) ? ST_COMMIT : ST_SCAN;
            end
         end
         ST_SCAN: begin
            // cnt_reg indexes the address on the bus; data for cnt_reg-1 is on rd_data.
            rd_idx_next = cnt_reg + 8'd1;
            cnt_next    = cnt_reg + 8'd1;
            if (cnt_reg != 8'd0 && bus.rd_data == {nh_x_reg, nh_y_reg}) begin
               game_over_next = 1'b1;
               state_next     = ST_OVER;
            end else if (cnt_reg == scan_n_reg) begin
               state_next = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            push_next      = 1'b1;
            pop_next       = !grow_reg;
            push_data_next = {nh_x_reg, nh_y_reg};
            head_x_next    = nh_x_reg;
            head_y_next    = nh_y_reg;
            ate_next       = eat_reg;
            state_next     = ST_RUN;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         head_x_reg     <= '0;
         head_y_reg     <= '0;
         nh_x_reg       <= '0;
         nh_y_reg       <= '0;
         dir_reg        <= 2'd1;
         game_over_reg  <= 1'b0;
         pending_reg    <= 1'b0;
         drain_wait_reg <= 1'b0;
         grow_reg       <= 1'b0;
         eat_reg        <= 1'b0;
         cnt_reg        <= 8'd0;
         scan_n_reg     <= 8'd0;
         rd_idx_reg     <= 8'd0;
         push_reg       <= 1'b0;
         pop_reg        <= 1'b0;
         ate_reg        <= 1'b0;
         push_data_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         head_x_reg     <= head_x_next;
         head_y_reg     <= head_y_next;
         nh_x_reg       <= nh_x_next;
         nh_y_reg       <= nh_y_next;
         dir_reg        <= dir_next;
         game_over_reg  <= game_over_next;
         pending_reg    <= pending_next;
         drain_wait_reg <= drain_wait_next;
         grow_reg       <= grow_next;
         eat_reg        <= eat_next;
         cnt_reg        <= cnt_next;
         scan_n_reg     <= scan_n_next;
         rd_idx_reg     <= rd_idx_next;
         push_reg       <= push_next;
         pop_reg        <= pop_next;
         ate_reg        <= ate_next;
         push_data_reg  <= push_data_next;
      end
   end

   assign bus.rd_idx    = rd_idx_reg;
   assign bus.push      = push_reg;
   assign bus.pop       = pop_reg;
   assign bus.push_data = push_data_reg;
   assign head_x        = head_x_reg;
   assign head_y        = head_y_reg;
   assign dir_out       = dir_reg;
   assign ate           = ate_reg;
   assign game_over     = game_over_reg;
   assign busy          = (state_reg != ST_IDLE) && (state_reg != ST_RUN);
endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Per-tick movement sequencer for the snake body store, which is a head-at-index-0 shift FIFO with push/pop/length.
- On each game tick it:
  - computes the next head from a direction input;
  - checks for wall and self collision by scanning the body through a read port;
  - issues a single push or push+pop to grow or move the snake.
- Also handles game start (seeding the initial body), game over, and restart (draining the store).

Parameters:
- XW, 6, x coordinate width
- YW, 5, y coordinate width
- GRID_W, 40, columns; legal x is 0..GRID_W-1
- GRID_H, 30, rows; legal y is 0..GRID_H-1
- MAX_LEN, 8, body store capacity
- INIT_LEN, 3, segments seeded on start (must be at least 1 and at most MAX_LEN)
- START_X, 20, initial head x
- START_Y, 15, initial head y

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins or restarts a game
- tick  in  1  one-cycle pulse; game step request
- dir_in  in  2  requested direction: 0=up (y-1), 1=right (x+1), 2=down (y+1), 3=left (x-1)
- food_x  in  XW  food column
- food_y  in  YW  food row
- body_len  in  8  store length output
- rd_idx  out  8  body read index
- rd_data  in  XW+YW  body entry {x,y}; valid the cycle after rd_idx is presented
- push  out  1  store push strobe
- pop  out  1  store pop strobe
- push_data  out  XW+YW  new head {x,y}
- head_x  out  XW  current head column
- head_y  out  YW  current head row
- dir_out  out  2  current direction
- ate  out  1  one-cycle pulse when food is consumed
- game_over  out  1  sticky collision flag
- busy  out  1  high in every state other than IDLE and RUN

Behaviour:
- Reset (async) values:
  - state=IDLE; push, pop, ate, game_over, busy all 0.
  - rd_idx=0, push_data=0, head=(0,0), dir_out=1, pending tick cleared.
- States: IDLE, DRAIN, SEED, RUN, CALC, SCAN, COMMIT, OVER.
- IDLE/OVER + start:
  - goto DRAIN; clear game_over; dir_out=1.
- DRAIN:
  - While body_len != 0, pop=1 for one cycle, then wait one cycle for body_len to update.
  - When body_len == 0, goto SEED.
- SEED:
  - INIT_LEN pushes on consecutive cycles, pop=0.
  - Segment k (k=0..INIT_LEN-1) is (START_X-INIT_LEN+1+k, START_Y).
  - head = (START_X, START_Y); then goto RUN.
- RUN + tick (or a pending tick) -> CALC:
  - Sample dir_in. If dir_in equals dir_out XOR 2 (a reversal), keep dir_out; else dir_out=dir_in.
- Tick arriving outside RUN:
  - While in CALC/SCAN/COMMIT, set a pending flag (max 1; further ticks are dropped).
  - In IDLE/DRAIN/SEED/OVER, drop it.
- CALC (1 cycle):
  - Wall check: dir up and y==0, right and x==GRID_W-1, down and y==GRID_H-1, or left and x==0 -> goto OVER, game_over=1, no push.
  - Otherwise form nh = head + step (no wrap).
  - grow = (nh == food) && body_len < MAX_LEN.
  - eat = (nh == food).
  - N = grow ? body_len : body_len-1. The tail is excluded when moving, since it vacates.
- SCAN:
  - Present rd_idx = 0..N-1 on consecutive cycles.
  - Compare rd_data to nh one cycle later.
  - Any match -> OVER, game_over=1, no push.
  - N==0 -> skip SCAN.
- COMMIT (1 cycle):
  - push=1, pop=!grow, push_data=nh.
  - head=nh; ate=eat (pulses even when the body is full and cannot grow).
  - Goto RUN.
- Every push, pop and ate is a single-cycle strobe. push and pop appear together only in COMMIT.
- OVER:
  - Outputs hold; game_over stays 1 until start.
  - No push or pop is issued.
- start in any state other than IDLE/OVER is ignored.

Test Plan:
- Reset, then start (defaults):
  - Pushes in order (18,15), (19,15), (20,15); body_len=3; head=(20,15); busy falls; pop never asserted.
- tick with dir_in=1, food=(0,0):
  - Exactly one cycle with push=1, pop=1, push_data=(21,15); body_len stays 3; ate=0.
- food=(22,15), tick with dir_in=1:
  - push=1, pop=0, ate pulses once, body_len=4.
  - Repeat with food=(23,15): body_len=5.
- dir_in=3 (reversal) on tick:
  - Head moves right to the next x; dir_out stays 1.
- Self collision from body (23,15),(22,15),(21,15),(20,15),(19,15):
  - Ticks up, left, down -> third tick sets game_over, since (22,15) is in the body; no push on that tick.
- Wall collision and restart:
  - Drive head to x=39 with dir right, then tick -> game_over=1, no strobes.
  - start -> pops until body_len=0, reseeds 3 segments, game_over=0.
  - A tick during SEED is ignored; two ticks during SCAN yield exactly one extra step.
